// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: register address width and the
// write-port grant encoding used by the writeback arbiter.
package pipeline_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    WB_NONE,
    WB_PIPE,
    WB_FIFO,
    WB_FORCE
  } wb_src_e;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bus bundle of the writeback port arbiter: pipeline W-stage request, MDU
// result handshake, D-stage hazard query and the regfile write port.
interface wb_port_arbiter_if
  import pipeline_pkg::*;
#(
  parameter int XLEN = 32
);

  logic                  pipe_we;
  logic [REG_ADDR_W-1:0] pipe_rd;
  logic [XLEN-1:0]       pipe_wd;
  logic                  mdu_valid;
  logic                  mdu_ready;
  logic [REG_ADDR_W-1:0] mdu_rd;
  logic [XLEN-1:0]       mdu_wd;
  logic [REG_ADDR_W-1:0] rs1_d;
  logic [REG_ADDR_W-1:0] rs2_d;
  logic                  raw_hazard;
  logic                  stall_w;
  logic                  rf_we;
  logic [REG_ADDR_W-1:0] rf_a3;
  logic [XLEN-1:0]       rf_wd;

  // The arbiter is the slave; the pipeline/MDU/regfile side is the master.
  modport slave (
    input  pipe_we, pipe_rd, pipe_wd,
    input  mdu_valid, mdu_rd, mdu_wd,
    input  rs1_d, rs2_d,
    output mdu_ready, raw_hazard, stall_w,
    output rf_we, rf_a3, rf_wd
  );

  modport master (
    output pipe_we, pipe_rd, pipe_wd,
    output mdu_valid, mdu_rd, mdu_wd,
    output rs1_d, rs2_d,
    input  mdu_ready, raw_hazard, stall_w,
    input  rf_we, rf_a3, rf_wd
  );

endinterface

// File: rtl/wb_fifo.sv
// MDU result buffer: circular FIFO of {valid, rd, wd} entries with per-entry
// kill on destination match and a RAW compare against the D-stage sources.
module wb_fifo
  import pipeline_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_i,
  input  logic [REG_ADDR_W-1:0] push_rd_i,
  input  logic [XLEN-1:0]       push_wd_i,
  input  logic                  pop_i,
  input  logic                  kill_i,
  input  logic [REG_ADDR_W-1:0] kill_rd_i,
  input  logic [REG_ADDR_W-1:0] rs1_i,
  input  logic [REG_ADDR_W-1:0] rs2_i,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  head_valid_o,
  output logic [REG_ADDR_W-1:0] head_rd_o,
  output logic [XLEN-1:0]       head_wd_o,
  output logic                  hazard_o
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       wd;
  } entry_t;

  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [AW:0]   wrPtr_q, wrPtr_d;
  logic [AW:0]   rdPtr_q, rdPtr_d;
  logic [AW-1:0] wrIdx, rdIdx;

  assign wrIdx = wrPtr_q[AW-1:0];
  assign rdIdx = rdPtr_q[AW-1:0];

  assign empty_o = (wrPtr_q == rdPtr_q);
  assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrIdx == rdIdx);

  assign head_valid_o = mem_q[rdIdx].valid;
  assign head_rd_o    = mem_q[rdIdx].rd;
  assign head_wd_o    = mem_q[rdIdx].wd;

  // Popped slots get their valid bit cleared, so unoccupied slots never
  // match in the kill or hazard logic. Push lands after the kill so a
  // same-cycle arrival is stored valid.
  always_comb begin
    mem_d   = mem_q;
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (kill_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (mem_q[i].rd == kill_rd_i) mem_d[i].valid = 1'b0;
      end
    end
    if (pop_i) begin
      mem_d[rdIdx].valid = 1'b0;
      rdPtr_d            = rdPtr_q + 1'b1;
    end
    if (push_i) begin
      mem_d[wrIdx] = '{valid: 1'b1, rd: push_rd_i, wd: push_wd_i};
      wrPtr_d      = wrPtr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  always_comb begin
    hazard_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mem_q[i].valid && (mem_q[i].rd != '0) &&
          ((mem_q[i].rd == rs1_i) || (mem_q[i].rd == rs2_i)))
        hazard_o = 1'b1;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the regfile write port between the W stage and buffered MDU results.
// Define WB_ARB_STARVE_EN to enable the starvation counter and forced drain.
module wb_port_arbiter
  import pipeline_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  wb_port_arbiter_if.slave        bus
);

  wb_src_e               wbSrc;
  logic                  fifoEmpty, fifoFull, fifoHazard;
  logic                  headValid;
  logic [REG_ADDR_W-1:0] headRd;
  logic [XLEN-1:0]       headWd;
  logic                  pipeReq, forceDrain, push, pop;

  // Reset gates the handshake and write port so nothing leaks out while held.
  assign bus.mdu_ready = reset && !fifoFull;
  assign push          = bus.mdu_valid && bus.mdu_ready && (bus.mdu_rd != '0);
  assign pipeReq       = bus.pipe_we && (bus.pipe_rd != '0);

`ifdef WB_ARB_STARVE_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve_q, starve_d;

  assign forceDrain = (starve_q == SW'(STARVE_LIMIT)) && !fifoEmpty;

  always_comb begin
    starve_d = starve_q;
    if (fifoEmpty || pop)                  starve_d = '0;
    else if (starve_q != SW'(STARVE_LIMIT)) starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) starve_q <= '0;
    else        starve_q <= starve_d;
  end
`else
  assign forceDrain = 1'b0;
`endif

  always_comb begin
    wbSrc = WB_NONE;
    if (!reset)          wbSrc = WB_NONE;
    else if (forceDrain) wbSrc = WB_FORCE;
    else if (pipeReq)    wbSrc = WB_PIPE;
    else if (!fifoEmpty) wbSrc = WB_FIFO;
  end

  assign pop         = (wbSrc == WB_FORCE) || (wbSrc == WB_FIFO);
  assign bus.stall_w = (wbSrc == WB_FORCE);

  // A killed head still pops but leaves the write enable low.
  always_comb begin
    bus.rf_we = 1'b0;
    bus.rf_a3 = '0;
    bus.rf_wd = '0;
    case (wbSrc)
      WB_PIPE: begin
        bus.rf_we = 1'b1;
        bus.rf_a3 = bus.pipe_rd;
        bus.rf_wd = bus.pipe_wd;
      end
      WB_FIFO, WB_FORCE: begin
        if (headValid) begin
          bus.rf_we = 1'b1;
          bus.rf_a3 = headRd;
          bus.rf_wd = headWd;
        end
      end
      default: ;
    endcase
  end

  assign bus.raw_hazard = reset && fifoHazard;

  wb_fifo #(
    .XLEN  (XLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_i       (push),
    .push_rd_i    (bus.mdu_rd),
    .push_wd_i    (bus.mdu_wd),
    .pop_i        (pop),
    .kill_i       (wbSrc == WB_PIPE),
    .kill_rd_i    (bus.pipe_rd),
    .rs1_i        (bus.rs1_d),
    .rs2_i        (bus.rs2_d),
    .empty_o      (fifoEmpty),
    .full_o       (fifoFull),
    .head_valid_o (headValid),
    .head_rd_o    (headRd),
    .head_wd_o    (headWd),
    .hazard_o     (fifoHazard)
  );

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter; expectations follow WB_ARB_STARVE_EN
// when the macro is defined for the build.
module tb_wb_port_arbiter;
  import pipeline_pkg::*;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  logic [31:0] regModel [32];

  wb_port_arbiter_if #(.XLEN(32)) bus ();

  wb_port_arbiter #(
    .XLEN         (32),
    .FIFO_DEPTH   (2),
    .STARVE_LIMIT (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.rf_we) regModel[bus.rf_a3] <= bus.rf_wd;
  end

  task automatic applyStimulus(input logic pw, input logic [4:0] prd,
                               input logic [31:0] pwd, input logic mv,
                               input logic [4:0] mrd, input logic [31:0] mwd,
                               input logic [4:0] r1, input logic [4:0] r2);
    bus.pipe_we   = pw;
    bus.pipe_rd   = prd;
    bus.pipe_wd   = pwd;
    bus.mdu_valid = mv;
    bus.mdu_rd    = mrd;
    bus.mdu_wd    = mwd;
    bus.rs1_d     = r1;
    bus.rs2_d     = r2;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;

    // Reset holds outputs low even with a live pipe request.
    applyStimulus(1, 3, 32'h33, 1, 4, 32'h44, 0, 0);
    checkOutput("rst_ready", {31'd0, bus.mdu_ready}, 32'd0);
    checkOutput("rst_we", {31'd0, bus.rf_we}, 32'd0);
    checkOutput("rst_stall", {31'd0, bus.stall_w}, 32'd0);
    checkOutput("rst_haz", {31'd0, bus.raw_hazard}, 32'd0);
    stepClock();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    #1;
    checkOutput("rel_ready", {31'd0, bus.mdu_ready}, 32'd1);
    checkOutput("rel_we", {31'd0, bus.rf_we}, 32'd0);
    stepClock();

    // MDU-only write.
    applyStimulus(0, 0, 0, 1, 5, 32'hDEAD_BEEF, 0, 0);
    checkOutput("mdu_ready", {31'd0, bus.mdu_ready}, 32'd1);
    checkOutput("mdu_we0", {31'd0, bus.rf_we}, 32'd0);
    stepClock();
    applyStimulus(0, 0, 0, 0, 0, 0, 5, 0);
    checkOutput("mdu_we1", {31'd0, bus.rf_we}, 32'd1);
    checkOutput("mdu_a3", {27'd0, bus.rf_a3}, 32'd5);
    checkOutput("mdu_wd", bus.rf_wd, 32'hDEAD_BEEF);
    checkOutput("mdu_haz1", {31'd0, bus.raw_hazard}, 32'd1);
    stepClock();
    applyStimulus(0, 0, 0, 0, 0, 0, 5, 0);
    checkOutput("mdu_we2", {31'd0, bus.rf_we}, 32'd0);
    checkOutput("mdu_haz2", {31'd0, bus.raw_hazard}, 32'd0);
    checkOutput("mdu_reg5", regModel[5], 32'hDEAD_BEEF);
    stepClock();

    // Hazard on buffered rd=12, then an rd=0 push that must not be stored.
    applyStimulus(1, 3, 32'h33, 1, 12, 32'h12, 0, 0);
    stepClock();
    applyStimulus(1, 3, 32'h33, 1, 0, 32'hAA, 0, 12);
    checkOutput("haz_rs2", {31'd0, bus.raw_hazard}, 32'd1);
    checkOutput("haz_pipe_a3", {27'd0, bus.rf_a3}, 32'd3);
    checkOutput("haz_rd0_ready", {31'd0, bus.mdu_ready}, 32'd1);
    stepClock();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("haz_rs0", {31'd0, bus.raw_hazard}, 32'd0);
    checkOutput("haz_drain_a3", {27'd0, bus.rf_a3}, 32'd12);
    stepClock();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("haz_rd0_nostore", {31'd0, bus.rf_we}, 32'd0);
    stepClock();

    // WAW kill: pipe overwrites r9 while r9 sits in the FIFO.
    applyStimulus(1, 3, 32'h33, 1, 9, 32'h99, 0, 0);
    stepClock();
    applyStimulus(1, 9, 32'h1, 0, 0, 0, 0, 0);
    checkOutput("waw_a3", {27'd0, bus.rf_a3}, 32'd9);
    checkOutput("waw_wd", bus.rf_wd, 32'h1);
    stepClock();
    applyStimulus(0, 0, 0, 0, 0, 0, 9, 0);
    checkOutput("waw_kill_we", {31'd0, bus.rf_we}, 32'd0);
    checkOutput("waw_kill_a3", {27'd0, bus.rf_a3}, 32'd0);
    checkOutput("waw_haz", {31'd0, bus.raw_hazard}, 32'd0);
    stepClock();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("waw_reg9", regModel[9], 32'h1);
    stepClock();

    // Full FIFO and back-pressure; a pop-only cycle admits no push.
    applyStimulus(1, 3, 32'h33, 1, 20, 32'h20, 0, 0);
    stepClock();
    applyStimulus(1, 3, 32'h33, 1, 21, 32'h21, 0, 0);
    checkOutput("full_ready1", {31'd0, bus.mdu_ready}, 32'd1);
    stepClock();
    applyStimulus(1, 3, 32'h33, 1, 22, 32'h22, 0, 0);
    checkOutput("full_ready2", {31'd0, bus.mdu_ready}, 32'd0);
    stepClock();
    applyStimulus(0, 0, 0, 1, 22, 32'h22, 0, 0);
    checkOutput("full_poponly_ready", {31'd0, bus.mdu_ready}, 32'd0);
    checkOutput("full_pop_a3", {27'd0, bus.rf_a3}, 32'd20);
    stepClock();
    applyStimulus(0, 0, 0, 1, 22, 32'h22, 0, 0);
    checkOutput("full_ready3", {31'd0, bus.mdu_ready}, 32'd1);
    checkOutput("full_pop2_a3", {27'd0, bus.rf_a3}, 32'd21);
    stepClock();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("full_pop3_a3", {27'd0, bus.rf_a3}, 32'd22);
    checkOutput("full_pop3_wd", bus.rf_wd, 32'h22);
    stepClock();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("full_empty_we", {31'd0, bus.rf_we}, 32'd0);
    stepClock();

    // Contention between a buffered rd=7 and a continuous pipe write.
    applyStimulus(1, 3, 32'h33, 1, 7, 32'h77, 0, 0);
    stepClock();
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1, 3, 32'h33, 0, 0, 0, 0, 0);
      checkOutput($sformatf("cont_stall%0d", k), {31'd0, bus.stall_w}, 32'd0);
      checkOutput($sformatf("cont_a3_%0d", k), {27'd0, bus.rf_a3}, 32'd3);
      stepClock();
    end
`ifdef WB_ARB_STARVE_EN
    applyStimulus(1, 3, 32'h33, 0, 0, 0, 0, 0);
    checkOutput("cont_force_stall", {31'd0, bus.stall_w}, 32'd1);
    checkOutput("cont_force_a3", {27'd0, bus.rf_a3}, 32'd7);
    checkOutput("cont_force_wd", bus.rf_wd, 32'h77);
    stepClock();
    applyStimulus(1, 3, 32'h33, 0, 0, 0, 0, 0);
    checkOutput("cont_resume_stall", {31'd0, bus.stall_w}, 32'd0);
    checkOutput("cont_resume_a3", {27'd0, bus.rf_a3}, 32'd3);
    stepClock();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("cont_idle_we", {31'd0, bus.rf_we}, 32'd0);
    stepClock();
`else
    for (int k = 5; k <= 6; k++) begin
      applyStimulus(1, 3, 32'h33, 0, 0, 0, 0, 0);
      checkOutput($sformatf("cont_stall%0d", k), {31'd0, bus.stall_w}, 32'd0);
      checkOutput($sformatf("cont_a3_%0d", k), {27'd0, bus.rf_a3}, 32'd3);
      stepClock();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("cont_drain_a3", {27'd0, bus.rf_a3}, 32'd7);
    checkOutput("cont_drain_wd", bus.rf_wd, 32'h77);
    stepClock();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("cont_idle_we", {31'd0, bus.rf_we}, 32'd0);
    stepClock();
`endif

    // Reset with two entries queued and the starve count at 3.
    applyStimulus(1, 3, 32'h33, 1, 30, 32'h30, 0, 0);
    stepClock();
    applyStimulus(1, 3, 32'h33, 1, 31, 32'h31, 0, 0);
    stepClock();
    applyStimulus(1, 3, 32'h33, 0, 0, 0, 0, 0);
    stepClock();
    applyStimulus(1, 3, 32'h33, 0, 0, 0, 0, 0);
    stepClock();
    applyStimulus(1, 3, 32'h33, 0, 0, 0, 30, 0);
    checkOutput("mid_haz_pre", {31'd0, bus.raw_hazard}, 32'd1);
    checkOutput("mid_stall_pre", {31'd0, bus.stall_w}, 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("mid_rst_ready", {31'd0, bus.mdu_ready}, 32'd0);
    checkOutput("mid_rst_we", {31'd0, bus.rf_we}, 32'd0);
    checkOutput("mid_rst_stall", {31'd0, bus.stall_w}, 32'd0);
    checkOutput("mid_rst_haz", {31'd0, bus.raw_hazard}, 32'd0);
    stepClock();
    applyStimulus(0, 0, 0, 0, 0, 0, 30, 31);
    reset = 1'b1;
    #1;
    checkOutput("mid_rel_ready", {31'd0, bus.mdu_ready}, 32'd1);
    checkOutput("mid_rel_we", {31'd0, bus.rf_we}, 32'd0);
    checkOutput("mid_rel_haz", {31'd0, bus.raw_hazard}, 32'd0);
    stepClock();
    applyStimulus(0, 0, 0, 0, 0, 0, 30, 31);
    checkOutput("mid_nostale_we", {31'd0, bus.rf_we}, 32'd0);
    checkOutput("mid_nostale_stall", {31'd0, bus.stall_w}, 32'd0);
    stepClock();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the register file's single write port between two sources. The first is the in-order pipeline writeback (W stage). The second is the out-of-pipeline multi-cycle unit (MDU), which returns results asynchronously to the pipeline. The block buffers MDU results in a small FIFO and drives the regfile write port (`we3/a3/wd3`). It reports read-after-write hazards on buffered destinations to the hazard unit, and stalls the pipeline when an MDU result has waited too long.

## Interface
Parameters:
- `XLEN`, 32, data width.
- `FIFO_DEPTH`, 2, MDU result buffer entries (power of two, ≥2).
- `STARVE_LIMIT`, 4, cycles a FIFO head may be denied before a forced drain.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low (0 = reset).
- `pipe_we`  in  1  W-stage write request (RegWriteW).
- `pipe_rd`  in  5  W-stage destination.
- `pipe_wd`  in  XLEN  W-stage result.
- `mdu_valid`  in  1  MDU result offered.
- `mdu_ready`  out  1  FIFO can accept.
- `mdu_rd`  in  5  MDU destination.
- `mdu_wd`  in  XLEN  MDU result.
- `rs1_d`, `rs2_d`  in  5 each  D-stage source registers.
- `raw_hazard`  out  1  a valid buffered entry targets `rs1_d` or `rs2_d`.
- `stall_w`  out  1  freeze W stage and upstream this cycle.
- `rf_we`  out  1  regfile write enable.
- `rf_a3`  out  5  regfile write address.
- `rf_wd`  out  XLEN  regfile write data.

## Operation
- FIFO entry holds `{valid, rd, wd}`. A push occurs on `mdu_valid && mdu_ready`. `mdu_ready = !full`, where `full` is computed from registered state only. A same-cycle pop does not admit a push into a full FIFO.
- MDU results with `mdu_rd == 0` complete the handshake but are not stored.
- Write-port grant is evaluated every cycle, in priority order:
  1. Forced drain: `starve == STARVE_LIMIT` and FIFO non-empty. Assert `stall_w`, write the head, pop it. The pipe write is not performed; the frozen pipeline re-presents it next cycle.
  2. Pipe write: `pipe_we && pipe_rd != 0`. Write pipe data.
  3. Otherwise, if the FIFO is non-empty, write the head and pop it.
- Invalidated head: if the head's valid bit is clear, it pops without asserting `rf_we`. Popping it counts as a grant.
- WAW kill: on a granted pipe write, clear valid on every entry already in the FIFO whose `rd == pipe_rd`. An entry being pushed in the same cycle is stored valid.
- `starve` counter:
  - Increments (saturating at `STARVE_LIMIT`) when the FIFO is non-empty and the head is not popped.
  - Clears on any pop and whenever the FIFO is empty.
- `raw_hazard` is combinational from registered FIFO state. It is asserted when any valid entry has a nonzero `rd` equal to `rs1_d` or `rs2_d`. Incoming `mdu_*` is excluded.
- `rf_*` outputs are combinational. When `rf_we = 0`, `rf_a3` and `rf_wd` are 0.

## Timing
- Reset (asynchronous assert, synchronous release):
  - FIFO empty, all valid bits 0, `starve = 0`.
  - While `reset = 0`: `mdu_ready = 0`, `rf_we = 0`, `stall_w = 0`, `raw_hazard = 0`.
  - An in-flight MDU handshake is lost; the MDU is reset by the same signal.
- MDU accept in cycle N: earliest regfile write is cycle N+1. The value is visible to a D-stage read in cycle N+2 (regfile write-first behaviour governs).
- With `pipe_we` held high, a head accepted in cycle N drains at the latest in cycle N+1+`STARVE_LIMIT`. `stall_w` is high for exactly one cycle per forced drain.
- FIFO pointers wrap modulo `FIFO_DEPTH`, with an extra occupancy bit to distinguish full from empty.

## Configuration
- `WB_ARB_STARVE_EN`:
  - Defined: the starvation counter and forced drain exist as described.
  - Undefined: no counter; `stall_w` is tied 0; the FIFO drains only on cycles without a granted pipe write. The MDU back-pressures via `mdu_ready` indefinitely.

## Structure
- `pipeline_pkg` gains:
  - `REG_ADDR_W = 5`
  - `wb_src_e` (`WB_NONE`, `WB_PIPE`, `WB_FIFO`, `WB_FORCE`) for grant encoding.
- Entry struct is declared locally, since it depends on `XLEN`.
- One sub-module: `wb_fifo` (storage, pointers, per-entry kill by rd match, head/full/empty, hazard compare outputs). Grant, counter and output muxing stay in the top.

## Test plan
- MDU-only: push `rd=5, wd=0xDEAD_BEEF` in cycle 1 with `pipe_we=0` → `rf_we=1, rf_a3=5, rf_wd=0xDEADBEEF` in cycle 2; FIFO empty in cycle 3.
- Contention: FIFO holds `rd=7`, `pipe_we=1` continuously with `pipe_rd=3`. With `WB_ARB_STARVE_EN` → head waits 4 cycles, `stall_w=1` on the 5th with `rf_a3=7`, then pipe writes resume. Without the macro → no stall, and `rd=7` never writes until `pipe_we` drops.
- WAW kill: FIFO holds `rd=9`, pipe writes `rd=9, wd=1` → next idle cycle pops the entry with `rf_we=0`. Register 9 ends at 1.
- Full/back-pressure: two pushes with `pipe_we=1` → `mdu_ready=0`. A pop-only cycle does not admit a third push until the following cycle.
- Hazard: FIFO holds `rd=12`, `rs2_d=12` → `raw_hazard=1`. `rs1_d=0` with an `rd=0` push → `raw_hazard=0`, nothing stored.
- Reset mid-operation: assert `reset=0` with 2 entries queued and `starve=3` → all outputs 0 immediately. After release, `mdu_ready=1`, FIFO empty, and no stale write occurs.
